// File: rtl/slice_assembler.sv
// Assembles a WORD_W-bit word from addressed SLICE_W-bit slices and single-bit
// writes, then hands the finished word to a valid/ready output register.
module slice_assembler #(
  parameter  int WORD_W  = 8,
  parameter  int SLICE_W = 4,
  parameter  int ADDR_W  = 4,
  localparam int NSLICES = WORD_W / SLICE_W,
  localparam int BIT_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [SLICE_W-1:0] in_slice,
  input  logic               bit_we,
  input  logic [BIT_W-1:0]   bit_idx,
  input  logic               bit_val,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               addr_err,
  output logic [7:0]         word_count
);

  // state | meaning
  // FILL  | accepting slice and bit writes into the assembly register
  // FULL  | assembly complete, waiting for the output register to free up
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [0:0]         state;
  logic [WORD_W-1:0]  asm_q;
  logic [NSLICES-1:0] mask_q;

  logic [NSLICES-1:0] hit;
  logic [NSLICES-1:0] slot_we;
  logic [NSLICES-1:0] mask_n;
  logic [WORD_W-1:0]  merged;
  logic               accept;
  logic               complete;
  logic               out_free;
  logic               addr_err_n;

  assign in_ready = (state == FILL);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_comb begin
    hit = '0;
    for (int s = 0; s < NSLICES; s++)
      if (in_addr == ADDR_W'(s)) hit[s] = 1'b1;
    slot_we = accept ? hit : '0;

    // Bit write goes in first so an overlapping slice write overrides it.
    merged = asm_q;
    if (state == FILL && bit_we)
      for (int b = 0; b < WORD_W; b++)
        if (bit_idx == BIT_W'(b)) merged[b] = bit_val;
    for (int s = 0; s < NSLICES; s++)
      if (slot_we[s]) merged[s*SLICE_W +: SLICE_W] = in_slice;

    mask_n     = mask_q | slot_we;
    complete   = (|slot_we) && (&mask_n);
    addr_err_n = accept && !(|hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      asm_q      <= '0;
      mask_q     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      addr_err   <= 1'b0;
      word_count <= '0;
    end else begin
      addr_err <= addr_err_n;
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        FILL: begin
          if (complete && out_free) begin
            out_data   <= merged;
            out_valid  <= 1'b1;
            asm_q      <= '0;
            mask_q     <= '0;
            word_count <= word_count + 8'd1;
          end else begin
            asm_q  <= merged;
            mask_q <= mask_n;
            if (complete) state <= FULL;
          end
        end
        FULL: begin
          if (out_free) begin
            out_data   <= asm_q;
            out_valid  <= 1'b1;
            asm_q      <= '0;
            mask_q     <= '0;
            word_count <= word_count + 8'd1;
            state      <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: doc/slice_assembler.md
Name: slice_assembler

Overview:
- Inverse of bit-slice extraction: builds a WORD_W-bit word from SLICE_W-bit slices written at addressed slice positions, plus optional single-bit writes.
- Each accepted slice lands at word[addr*SLICE_W +: SLICE_W]. When every slice position has been written, the assembled word is emitted on a valid/ready output register.
- Sits between narrow field producers (nibble/bit sources) and word-wide consumers in the test datapath.

Parameters:
- WORD_W, 8, assembled word width; must be an integer multiple of SLICE_W.
- SLICE_W, 4, width of one slice.
- ADDR_W, 4, width of slice address port.
- (localparam) NSLICES = WORD_W/SLICE_W; BIT_W = clog2(WORD_W).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  slice write request.
- in_ready  out  1  slice write accepted when in_valid&&in_ready.
- in_addr  in  ADDR_W  slice index.
- in_slice  in  SLICE_W  slice data.
- bit_we  in  1  single-bit write strobe, no handshake.
- bit_idx  in  BIT_W  bit position.
- bit_val  in  1  bit value.
- out_valid  out  1  assembled word available.
- out_ready  in  1  consumer accepts word.
- out_data  out  WORD_W  assembled word.
- addr_err  out  1  one-cycle pulse on an accepted write with in_addr>=NSLICES.
- word_count  out  8  number of words handed off to the output register; wraps 255->0.

Behaviour:
- Reset (sync, rst=1 at clk edge): asm register=0, fill mask=0, state=FILL, out_valid=0, out_data=0, addr_err=0, word_count=0. Reset mid-assembly or while out_valid=1 discards all data, with no handoff.
- Two registers: assembly register (asm plus NSLICES-bit fill mask) and output register (out_data/out_valid).
- FSM states:
  - FILL: in_ready=1.
  - FULL: in_ready=0; assembly is complete and waiting for the output register.
- Accepted slice write, addr<NSLICES: asm slice[addr] <= in_slice; mask[addr] <= 1. Rewriting an already-filled slot overwrites the data; the mask is unchanged and no error is raised.
- Accepted write, addr>=NSLICES: no data or mask change; addr_err=1 on the next cycle for one cycle.
- bit_we (effective only in FILL): asm[bit_idx] <= bit_val; the mask is unchanged.
  - Same cycle as a slice write covering that bit: the slice value wins.
  - Non-overlapping bit write in the same cycle: both apply.
  - bit_we in FULL: ignored.
- Completion: the cycle where the next mask would become all-ones defines the merged word M (current asm plus this cycle's slice and bit writes).
  - If out_valid=0, or out_valid&&out_ready in that cycle: next cycle out_data=M, out_valid=1, asm=0, mask=0, word_count+1, state stays FILL. Latency is one cycle from the final slice acceptance to out_valid.
  - Otherwise: asm<=M, mask stays full, state->FULL.
- FULL: in a cycle with out_valid=0, or out_valid&&out_ready: next cycle out_data=asm, out_valid=1, asm/mask cleared, word_count+1, state->FILL.
- Output handshake:
  - out_valid&&out_ready with no new handoff: out_valid->0 next cycle; out_data holds its last value.
  - out_data/out_valid stable while out_valid&&!out_ready.
- Throughput: with out_ready tied high, one word per NSLICES accepted slices, with no bubbles on in_ready.
- NSLICES=1: every valid write completes a word.

Test Plan:
1. Reset, then write addr0=4'hA and addr1=4'h5, out_ready=1 -> out_valid=1 one cycle after the second accept, out_data=8'h5A, word_count=1, in_ready stays 1.
2. Write addr1=4'h3, addr1=4'hC (overwrite), addr0=4'h1 -> out_data=8'hC1. Only one word emitted.
3. out_ready=0: complete word 8'h21, then complete 8'h43 -> state FULL, in_ready=0, out_data stays 8'h21. Raise out_ready -> next cycle out_data=8'h43, in_ready=1, word_count=2.
4. Write addr=4'h7, data 4'hF -> addr_err pulses one cycle; mask and asm are unchanged; a following write pair 0x0/0x0 yields 8'h00.
5. Write addr0=4'h0, then the same cycle as addr1=4'h0 write bit_we with bit_idx=3, bit_val=1 -> out_data=8'h08. A second word where bit_idx=5 coincides with the addr1 slice write of 4'h0 -> bit 5=0 (slice wins).
6. Assert rst with out_valid=1 and one slice pending -> next cycle out_valid=0, word_count=0. The next two writes produce a fresh word with no stale bits; also emit 256 words to confirm word_count wraps to 0.
